// File: rtl/definitions.sv
// rtl/definitions.sv - shared types for the data-memory port arbiter
package definitions;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_DATA_W = 32;
    localparam int REG_IDX_W  = 5;

    typedef logic [PKG_DATA_W-1:0] Register;
    typedef logic [REG_IDX_W-1:0]  reg_idx_t;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        Register               val;
        reg_idx_t              dst;
    } m_data_t;

    typedef struct packed {
        logic    read;
        logic    write;
        m_data_t data;
    } M_input;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
    typedef enum logic {OWN_IF, OWN_M} arb_owner_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [PKG_ADDR_W-1:0] addr;
        Register               wdata;
    } mem_port_req;

endpackage

// File: rtl/mem_arb_starve_guard.sv
// rtl/mem_arb_starve_guard.sv - counts M wins over a waiting IF and forces IF ahead at the limit
module mem_arb_starve_guard #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic m_grant_if_waiting,
    input  logic if_grant,
    output logic force_if
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (if_grant) begin
            cnt <= '0;
        end else if (m_grant_if_waiting && cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_if = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-memory port between IF and M, one transaction at a time
// Optional IF anti-starvation guard enabled by MEM_ARB_STARVE_EN.
module mem_port_arbiter
    import definitions::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  M_input            m_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              m_done,
    output logic [DATA_W-1:0] m_rdata,
    output reg_idx_t          m_wb_dst,
    output logic              stall_if,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e  state;
    arb_owner_e  owner;
    mem_port_req req_q;

    logic m_pend;
    logic grant;
    logic pick_if;
    logic force_if;

    assign m_pend  = m_in.read | m_in.write;
    assign grant   = (state == IDLE) & (m_pend | if_req);
    assign pick_if = if_req & (~m_pend | force_if);

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve_guard #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_guard (
        .clk                (clk),
        .rst                (rst),
        .m_grant_if_waiting (grant & ~pick_if & if_req),
        .if_grant           (grant & pick_if),
        .force_if           (force_if)
    );
`else
    // Fixed priority: a limit can never be reached, so IF never jumps ahead.
    assign force_if = (STARVE_LIMIT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            req_q    <= '0;
            if_done  <= 1'b0;
            m_done   <= 1'b0;
            if_rdata <= '0;
            m_rdata  <= '0;
            m_wb_dst <= '0;
        end else begin
            if_done <= 1'b0;
            m_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= ISSUE;
                        req_q.req <= 1'b1;
                        if (pick_if) begin
                            owner      <= OWN_IF;
                            req_q.we   <= 1'b0;
                            req_q.addr <= PKG_ADDR_W'(if_addr);
                        end else begin
                            // read+write together is treated as a write
                            owner       <= OWN_M;
                            req_q.we    <= m_in.write;
                            req_q.addr  <= m_in.data.addr;
                            req_q.wdata <= m_in.data.val;
                            m_wb_dst    <= m_in.data.dst;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        req_q.req <= 1'b0;
                        if (req_q.we) begin
                            state <= RESP;
                            if (owner == OWN_IF) if_done <= 1'b1;
                            else                 m_done  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= RESP;
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            m_rdata <= mem_rdata;
                            m_done  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    // requester advances this cycle; re-arbitrate only from IDLE
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req   = req_q.req;
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr[ADDR_W-1:0];
    assign mem_wdata = req_q.wdata[DATA_W-1:0];

    assign stall_if = if_req & ~((state == RESP) & (owner == OWN_IF));
    assign stall_m  = m_pend & ~((state == RESP) & (owner == OWN_M));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import definitions::*;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    M_input      m_in = '0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done, m_done, stall_if, stall_m, mem_req, mem_we;
    logic [31:0] if_rdata, m_rdata, mem_addr, mem_wdata;
    reg_idx_t    m_wb_dst;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .m_in(m_in), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_rdata(if_rdata), .m_done(m_done), .m_rdata(m_rdata),
        .m_wb_dst(m_wb_dst), .stall_if(stall_if), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_dly = 0;
    int rv_dly = 0;
    int inj_cyc = -1;

    // transaction-level model: one schedule per granted transaction
    bit          txn_live = 1'b0;
    bit          t_own_if = 1'b0;
    bit          t_we = 1'b0;
    int          t_issue, t_gnt, t_rv, t_done;
    int          free_at = 0;
    logic [31:0] t_addr = '0, t_wdata = '0, t_word = '0;
    reg_idx_t    t_dst = '0;
    logic [31:0] last_if = '0, last_m = '0;
    int          starve_n = 0;

    int req_cnt = 0, m_done_cnt = 0, if_done_cnt = 0, if_snap = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : ((a << 8) ^ 32'h5A5A_C3C3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory responder driven from the model's schedule
    initial begin
        bit rv_model;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            rv_model   = txn_live && !t_we && cyc == t_rv;
            mem_gnt    = txn_live && cyc == t_gnt;
            mem_rvalid = rv_model || cyc == inj_cyc;
            mem_rdata  = (cyc == inj_cyc) ? 32'h0000AAAA : (rv_model ? t_word : ~t_word);
        end
    end

    // compare process
    initial begin
        bit done_now, exp_req, mreq, take_if, starve_hit;
        forever begin
            @(negedge clk);
            if (mem_req) req_cnt++;
            if (m_done) m_done_cnt++;
            if (if_done) begin
                if_done_cnt++;
                if_snap = m_done_cnt;
            end
            if (rst) begin
                txn_live = 1'b0;
                free_at  = cyc + 1;
                last_if  = '0;
                last_m   = '0;
                starve_n = 0;
            end else begin
                done_now = txn_live && cyc == t_done;
                if (done_now && !t_we) begin
                    if (t_own_if) last_if = t_word;
                    else          last_m  = t_word;
                end
                exp_req = txn_live && cyc >= t_issue && cyc <= t_gnt;
                chk("mem_req", mem_req, exp_req);
                if (exp_req) begin
                    chk("mem_addr", mem_addr, t_addr);
                    chk("mem_we", mem_we, t_we);
                    if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
                end
                chk("if_done", if_done, done_now && t_own_if);
                chk("m_done", m_done, done_now && !t_own_if);
                chk("if_rdata", if_rdata, last_if);
                chk("m_rdata", m_rdata, last_m);
                if (done_now && !t_own_if) chk("m_wb_dst", m_wb_dst, t_dst);
                mreq = m_in.read | m_in.write;
                chk("stall_if", stall_if, if_req && !(done_now && t_own_if));
                chk("stall_m", stall_m, mreq && !(done_now && !t_own_if));

                if (cyc >= free_at && (mreq || if_req)) begin
`ifdef MEM_ARB_STARVE_EN
                    starve_hit = starve_n >= STARVE_LIMIT;
`else
                    starve_hit = 1'b0;
`endif
                    take_if = if_req && (!mreq || starve_hit);
                    if (take_if) starve_n = 0;
                    else if (if_req && starve_n < STARVE_LIMIT) starve_n++;
                    txn_live = 1'b1;
                    t_own_if = take_if;
                    t_we     = take_if ? 1'b0 : m_in.write;
                    t_addr   = take_if ? if_addr : m_in.data.addr;
                    t_wdata  = m_in.data.val;
                    t_dst    = m_in.data.dst;
                    t_word   = word_at(t_addr);
                    t_issue  = cyc + 1;
                    t_gnt    = cyc + 1 + gnt_dly;
                    t_rv     = t_gnt + 1 + rv_dly;
                    t_done   = t_we ? t_gnt + 1 : t_rv + 1;
                    free_at  = t_done + 1;
                end
            end
        end
    end

    task automatic m_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] v, input reg_idx_t d, output int lat);
        int c0;
        bit got;
        @(posedge clk); #1;
        m_in.read = rd; m_in.write = wr;
        m_in.data.addr = a; m_in.data.val = v; m_in.data.dst = d;
        c0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (m_done) got = 1'b1;
        end
        lat = cyc - c0;
        chk("m_txn_timeout", got, 1'b1);
    endtask

    task automatic m_clear();
        @(posedge clk); #1;
        m_in = '0;
    endtask

    task automatic if_txn(input logic [31:0] a, output int lat);
        int c0;
        bit got;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        c0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (if_done) got = 1'b1;
        end
        lat = cyc - c0;
        chk("if_txn_timeout", got, 1'b1);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int lat_m, lat_i, m0, i0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_m_wb_dst", m_wb_dst, 32'h0);
        chk("rst_done", {if_done, m_done}, 32'h0);

        // minimum-latency M read
        m_txn(1'b1, 1'b0, 32'h40, 32'h0, 5'd5, lat_m);
        chk("rd_latency", lat_m, 3);
        chk("rd_data", m_rdata, 32'hDEADBEEF);
        chk("rd_dst", m_wb_dst, 32'd5);
        m_clear();

        // M write with grant held off three cycles
        gnt_dly = 3;
        req_cnt = 0;
        m_txn(1'b0, 1'b1, 32'h80, 32'h1234, 5'd7, lat_m);
        chk("wr_latency", lat_m, 5);
        m_clear();
        chk("wr_req_cycles", req_cnt, 4);
        gnt_dly = 0;

        // IF and M together: M first, IF after M's RESP and an idle cycle
        i0 = if_done_cnt;
        fork
            begin
                m_txn(1'b1, 1'b0, 32'h44, 32'h0, 5'd3, lat_m);
                m_clear();
            end
            if_txn(32'h200, lat_i);
        join
        chk("both_m_latency", lat_m, 3);
        chk("both_if_latency", lat_i, 7);
        chk("both_if_done_once", if_done_cnt - i0, 1);
        chk("both_if_rdata", if_rdata, 32'h5A58_C3C3);

        // read and write both high behaves as a write
        m_txn(1'b1, 1'b1, 32'hC0, 32'h55, 5'd2, lat_m);
        chk("rw_latency", lat_m, 2);
        m_clear();

        // continuous M writes with IF waiting
        m0 = m_done_cnt;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    m_txn(1'b0, 1'b1, 32'h300 + 32'(k * 4), 32'h100 + 32'(k), 5'(k), lat_m);
                end
                m_clear();
            end
            if_txn(32'h400, lat_i);
        join
`ifdef MEM_ARB_STARVE_EN
        chk("starve_m_before_if", if_snap - m0, STARVE_LIMIT);
`else
        chk("starve_m_before_if", if_snap - m0, 6);
`endif

        // reset while waiting for read data; late rvalid must be ignored
        rv_dly = 6;
        m0 = m_done_cnt;
        @(posedge clk); #1;
        m_in.read = 1'b1; m_in.write = 1'b0;
        m_in.data.addr = 32'h100; m_in.data.val = '0; m_in.data.dst = 5'd9;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        m_in = '0;
        inj_cyc = cyc + 2;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_mem_req", mem_req, 1'b0);
        repeat (6) @(negedge clk);
        chk("rstw_no_done", m_done_cnt - m0, 0);
        chk("rstw_m_rdata", m_rdata, 32'h0);
        rv_dly = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port between the instruction-fetch stage (IF) and the memory stage (M), sequencing one transaction at a time over a gnt/rvalid handshake. Consumes the M-stage request bundle (`M_input`: read, write, addr, val, dst) after X→M forwarding. Returns read data and a one-cycle completion pulse to each requester, plus per-requester stall signals for the hazard unit.

## Interface
Parameters:
- `ADDR_W`, 32, memory address width
- `DATA_W`, 32, data width (matches `Register`)
- `STARVE_LIMIT`, 4, consecutive M grants with IF pending before IF is forced ahead (used only under macro)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `m_in`  in  `M_input`  M request: `read`, `write`, `data.addr`, `data.val`, `data.dst`
- `if_req`  in  1  IF fetch request, held until `if_done`
- `if_addr`  in  ADDR_W  fetch address
- `if_done`  out  1  one-cycle completion pulse to IF
- `if_rdata`  out  DATA_W  fetched word, valid with `if_done`
- `m_done`  out  1  one-cycle completion pulse to M
- `m_rdata`  out  DATA_W  load data, valid with `m_done` on reads
- `m_wb_dst`  out  `Register` index type  latched `data.dst`, valid with `m_done`
- `stall_if`  out  1  IF request pending and not completing this cycle
- `stall_m`  out  1  M request pending and not completing this cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  latched address
- `mem_wdata`  out  DATA_W  latched `data.val`
- `mem_gnt`  in  1  memory accepts request this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP; owner register ∈ {IF, M}.
- IDLE: M request = `m_in.read | m_in.write`. If any request, choose owner (M beats IF by default), latch addr/we/wdata/dst, go ISSUE. No request → stay.
- `read` and `write` both high: treated as write.
- ISSUE: `mem_req`=1 with latched fields, held stable until `mem_gnt`. On gnt: write → RESP; read → WAIT.
- WAIT: on `mem_rvalid` capture `mem_rdata` into owner's rdata register → RESP. `mem_rvalid` outside WAIT is ignored.
- RESP: pulse owner's `*_done` (and `m_wb_dst` for M) for exactly one cycle → IDLE. No arbitration in RESP; the requester advances this cycle, so a held request is never re-issued.
- `stall_x` = request from x asserted AND NOT (state==RESP AND owner==x). Combinational from inputs and state.
- `if_rdata`/`m_rdata` hold their last captured value between transactions.

## Timing
- Reset: state IDLE, owner IF, `mem_req`/`mem_we`/`if_done`/`m_done`=0, `mem_addr`/`mem_wdata`/`*_rdata`/`m_wb_dst`=0, starve counter 0.
- Minimum read: request seen cycle 0 (IDLE), `mem_req` cycle 1 with gnt, rvalid cycle 2, `*_done` cycle 3.
- Minimum write: cycle 0 IDLE, gnt cycle 1, `m_done` cycle 2.
- Wait states on gnt or rvalid extend ISSUE/WAIT without limit; all outputs held.
- Memory must not assert `mem_rvalid` in the gnt cycle.
- Reset mid-transaction: back to IDLE next edge, `mem_req` drops; late rvalid ignored.
- Back-to-back: after RESP, IDLE arbitrates on the following cycle; one idle cycle between transactions.

## Configuration
- `MEM_ARB_STARVE_EN` defined: counter increments on each M grant in IDLE while `if_req`=1, saturating at `STARVE_LIMIT`; at `STARVE_LIMIT`, next IDLE arbitration with both pending grants IF; counter clears on any IF grant or reset.
- Undefined: fixed priority, M always wins; counter logic absent.

## Structure
- Package `definitions`: `arb_state_e` (IDLE/ISSUE/WAIT/RESP), `arb_owner_e` (OWN_IF/OWN_M), `mem_port_req` struct (req, we, addr, wdata).
- Sub-module `mem_arb_starve_guard` (counter + force-IF output), instantiated only under `MEM_ARB_STARVE_EN`.

## Test plan
- M read addr 0x40, memory gnt cycle 1, rvalid cycle 2 data 0xDEADBEEF -> `m_done` cycle 3, `m_rdata`=0xDEADBEEF, `stall_m`=1 cycles 0–2.
- M write addr 0x80 val 0x1234, gnt delayed 3 cycles -> `mem_req` held 4 cycles with stable addr/wdata, `m_done` one cycle after gnt.
- IF and M request together cycle 0 -> M served first, IF `stall_if`=1 throughout, IF issued after M RESP+IDLE, `if_done` once.
- Reset asserted in WAIT, then rvalid 0xAAAA -> IDLE, no `*_done`, `m_rdata` stays 0.
- With `MEM_ARB_STARVE_EN`, STARVE_LIMIT=4, M requests continuously, `if_req` held -> IF granted after 4th M transaction; without macro IF never granted.
- read and write both high, val 0x55 -> `mem_we`=1, no rvalid wait, `m_done` after gnt.
